// File: rtl/shift_requant_pipe.sv
// Two-stage requantiser: shift/round in S1, clamp or wrap to OUT_W in S2.
// Valid/ready on both sides; sat_count tallies clamped beats taken downstream.
module shift_requant_pipe #(
    parameter int IN_W    = 16,
    parameter int OUT_W   = 8,
    parameter int SHIFT_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    data_in,
    input  logic [SHIFT_W-1:0] shift_amount,
    input  logic               shift_direction,
    input  logic               signed_mode,
    input  logic               round_en,
    input  logic               sat_en,
    input  logic               cnt_clear,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   data_out,
    output logic               sat_flag,
    output logic [CNT_W-1:0]   sat_count
);

    // One spare bit above the widest left shift keeps the sign exact.
    localparam int WW = IN_W + (1 << SHIFT_W);

    logic            s1_valid;
    logic            s2_valid;
    logic [WW-1:0]   s1_val;
    logic            s1_signed;
    logic            s1_sat;
    logic            s1_adv;
    logic            s2_adv;
    logic            in_fire;

    logic [WW-1:0]   ext;
    logic [WW-1:0]   one_w;
    logic [WW-1:0]   rnd_add;
    logic [WW-1:0]   sum;
    logic [WW-1:0]   shifted;

    logic [WW-1:0]   smax;
    logic [WW-1:0]   smin;
    logic [WW-1:0]   umax;
    logic [OUT_W-1:0] nar;
    logic            nar_flag;

    assign out_valid = s2_valid;
    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = reset_n && s1_adv;
    assign in_fire   = in_valid && in_ready;

    always_comb begin
        ext     = signed_mode ? {{(WW-IN_W){data_in[IN_W-1]}}, data_in}
                              : {{(WW-IN_W){1'b0}}, data_in};
        one_w   = {{(WW-1){1'b0}}, 1'b1};
        rnd_add = '0;
        if (round_en && shift_amount != '0)
            rnd_add = one_w << (shift_amount - SHIFT_W'(1));
        sum     = ext + rnd_add;
        if (shift_direction)
            shifted = ext << shift_amount;
        else if (signed_mode)
            shifted = $signed(sum) >>> shift_amount;
        else
            shifted = sum >> shift_amount;
    end

    always_comb begin
        smax = '0;
        smax[OUT_W-2:0] = '1;
        smin = '1;
        smin[OUT_W-2:0] = '0;
        umax = '0;
        umax[OUT_W-1:0] = '1;
        nar      = s1_val[OUT_W-1:0];
        nar_flag = 1'b0;
        if (s1_sat) begin
            if (s1_signed) begin
                if ($signed(s1_val) > $signed(smax)) begin
                    nar      = smax[OUT_W-1:0];
                    nar_flag = 1'b1;
                end else if ($signed(s1_val) < $signed(smin)) begin
                    nar      = smin[OUT_W-1:0];
                    nar_flag = 1'b1;
                end
            end else if (s1_val > umax) begin
                nar      = umax[OUT_W-1:0];
                nar_flag = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (in_fire) begin
            s1_val    <= shifted;
            s1_signed <= signed_mode;
            s1_sat    <= sat_en;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            data_out  <= '0;
            sat_flag  <= 1'b0;
            sat_count <= '0;
        end else begin
            if (s1_adv)
                s1_valid <= in_valid;
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    data_out <= nar;
                    sat_flag <= nar_flag;
                end
            end
            if (cnt_clear)
                sat_count <= '0;
            else if (s2_valid && out_ready && sat_flag && sat_count != '1)
                sat_count <= sat_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_shift_requant_pipe.sv
// Directed and randomised checks of shift_requant_pipe at default widths.
module tb_shift_requant_pipe;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] data_in;
    logic [3:0]  shift_amount;
    logic        shift_direction;
    logic        signed_mode;
    logic        round_en;
    logic        sat_en;
    logic        cnt_clear;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  data_out;
    logic        sat_flag;
    logic [15:0] sat_count;

    int checks   = 0;
    int failures = 0;

    shift_requant_pipe dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .shift_amount(shift_amount),
        .shift_direction(shift_direction), .signed_mode(signed_mode),
        .round_en(round_en), .sat_en(sat_en), .cnt_clear(cnt_clear),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .sat_flag(sat_flag), .sat_count(sat_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] d, input logic [3:0] s,
                         input logic dir, input logic sgn,
                         input logic rnd, input logic sat);
        data_in         = d;
        shift_amount    = s;
        shift_direction = dir;
        signed_mode     = sgn;
        round_en        = rnd;
        sat_en          = sat;
        in_valid        = 1'b1;
    endtask

    // Single beat through an empty pipe; also pins the 2-cycle latency.
    task automatic vec(input string tag, input logic [15:0] d,
                       input logic [3:0] s, input logic dir, input logic sgn,
                       input logic rnd, input logic sat,
                       input logic [7:0] eq, input logic ef);
        @(negedge clock);
        out_ready = 1'b1;
        drive(d, s, dir, sgn, rnd, sat);
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        #1;
        chk({tag, "_lat1"}, out_valid, 0);
        @(posedge clock);
        @(negedge clock);
        #1;
        chk({tag, "_lat2"}, out_valid, 1);
        chk({tag, "_data"}, data_out, eq);
        chk({tag, "_flag"}, sat_flag, ef);
        @(posedge clock);
    endtask

    function automatic void model(input logic [15:0] d, input logic [3:0] s,
                                  input logic dir, input logic sgn,
                                  input logic rnd, input logic sat,
                                  output logic [7:0] q, output logic f);
        longint v;
        longint hi;
        longint lo;
        v = sgn ? longint'($signed(d)) : longint'(d);
        if (dir) begin
            v = v << s;
        end else begin
            if (rnd && s != 0)
                v = v + (longint'(1) << (s - 1));
            v = v >>> s;
        end
        hi = sgn ? 127 : 255;
        lo = sgn ? -128 : 0;
        f = 1'b0;
        q = v[7:0];
        if (sat && v > hi) begin
            q = hi[7:0];
            f = 1'b1;
        end else if (sat && v < lo) begin
            q = lo[7:0];
            f = 1'b1;
        end
    endfunction

    initial begin
        logic [7:0]  eq[$];
        logic        ef[$];
        logic [7:0]  cq;
        logic        cf;
        logic        offering;
        int          sent;
        int          recvd;
        int          cyc;
        int          exp_cnt;

        reset_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        cnt_clear = 1'b0;
        drive(16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data", data_out, 0);
        chk("rst_flag", sat_flag, 0);
        chk("rst_count", sat_count, 0);
        reset_n = 1'b1;

        vec("r_u_wrap",  16'h55AA, 4'd4,  0, 0, 0, 0, 8'h5A, 0);
        vec("r_u_sat",   16'h55AA, 4'd4,  0, 0, 0, 1, 8'hFF, 1);
        vec("r_s_sat",   16'h55AA, 4'd4,  0, 1, 0, 1, 8'h7F, 1);
        vec("rnd_u_off", 16'h0018, 4'd4,  0, 0, 0, 0, 8'h01, 0);
        vec("rnd_u_on",  16'h0018, 4'd4,  0, 0, 1, 0, 8'h02, 0);
        vec("rnd_s_off", 16'hFFE8, 4'd4,  0, 1, 0, 0, 8'hFE, 0);
        vec("rnd_s_on",  16'hFFE8, 4'd4,  0, 1, 1, 0, 8'hFF, 0);
        vec("s15_s",     16'h8000, 4'd15, 0, 1, 0, 0, 8'hFF, 0);
        vec("s15_s_rnd", 16'h8000, 4'd15, 0, 1, 1, 0, 8'hFF, 0);
        vec("s15_u_rnd", 16'hFFFF, 4'd15, 0, 0, 1, 0, 8'h02, 0);
        vec("s0_rnd",    16'h00AB, 4'd0,  0, 0, 1, 0, 8'hAB, 0);
        vec("neg_clamp", 16'h8000, 4'd0,  0, 1, 0, 1, 8'h80, 1);
        vec("l_u",       16'h0003, 4'd3,  1, 0, 0, 0, 8'h18, 0);
        vec("l_s_wrap",  16'h0055, 4'd2,  1, 1, 0, 0, 8'h54, 0);
        vec("l_s_sat",   16'h0055, 4'd2,  1, 1, 1, 1, 8'h7F, 1);
        @(negedge clock);
        #1;
        chk("dir_count", sat_count, 4);

        // Backpressure: three beats offered against a stalled sink.
        @(negedge clock);
        out_ready = 1'b0;
        drive(16'h0100, 4'd4, 0, 0, 0, 0);
        #1;
        chk("bp_rdy_a", in_ready, 1);
        @(posedge clock);
        @(negedge clock);
        drive(16'h0200, 4'd4, 0, 0, 0, 0);
        #1;
        chk("bp_rdy_b", in_ready, 1);
        @(posedge clock);
        @(negedge clock);
        drive(16'h0300, 4'd4, 0, 0, 0, 0);
        #1;
        chk("bp_rdy_c", in_ready, 0);
        chk("bp_valid", out_valid, 1);
        chk("bp_head", data_out, 8'h10);
        repeat (3) begin
            @(posedge clock);
            @(negedge clock);
            #1;
            chk("bp_hold_data", data_out, 8'h10);
            chk("bp_hold_rdy", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rel_rdy", in_ready, 1);
        chk("bp_out_a", data_out, 8'h10);
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        #1;
        chk("bp_vld_b", out_valid, 1);
        chk("bp_out_b", data_out, 8'h20);
        @(posedge clock);
        @(negedge clock);
        #1;
        chk("bp_vld_c", out_valid, 1);
        chk("bp_out_c", data_out, 8'h30);
        @(posedge clock);
        @(negedge clock);
        #1;
        chk("bp_drained", out_valid, 0);

        // sat_count: five increments, then clear racing a sixth.
        cnt_clear = 1'b1;
        @(posedge clock);
        @(negedge clock);
        cnt_clear = 1'b0;
        #1;
        chk("cnt_clr0", sat_count, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            drive(16'h55AA, 4'd4, 0, 0, 0, 1);
        end
        @(negedge clock);
        in_valid = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        chk("cnt_five", sat_count, 5);
        @(negedge clock);
        drive(16'h55AA, 4'd4, 0, 0, 0, 1);
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        #1;
        chk("cnt_sixth_vld", out_valid, 1);
        cnt_clear = 1'b1;
        @(posedge clock);
        @(negedge clock);
        cnt_clear = 1'b0;
        #1;
        chk("cnt_clr_wins", sat_count, 0);
        @(posedge clock);
        @(negedge clock);
        #1;
        chk("cnt_clr_stays", sat_count, 0);

        // Reset with both stages full.
        vec("pre_rst", 16'h55AA, 4'd4, 0, 0, 0, 1, 8'hFF, 1);
        @(negedge clock);
        #1;
        chk("pre_rst_cnt", sat_count, 1);
        out_ready = 1'b0;
        drive(16'h0400, 4'd4, 0, 0, 0, 1);
        @(posedge clock);
        @(negedge clock);
        drive(16'h0500, 4'd4, 0, 0, 0, 1);
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        #1;
        chk("full_vld", out_valid, 1);
        chk("full_rdy", in_ready, 0);
        reset_n = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("in_rst_rdy", in_ready, 0);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("mid_rst_vld", out_valid, 0);
        chk("mid_rst_cnt", sat_count, 0);
        chk("mid_rst_data", data_out, 0);
        chk("mid_rst_flag", sat_flag, 0);
        chk("mid_rst_rdy", in_ready, 1);
        vec("post_rst", 16'h0700, 4'd4, 0, 0, 0, 0, 8'h70, 0);
        @(negedge clock);
        #1;
        chk("post_rst_empty", out_valid, 0);

        // Random valid/ready stream against the reference model.
        sent = 0;
        recvd = 0;
        cyc = 0;
        exp_cnt = 0;
        offering = 1'b0;
        while ((sent < 1000 || recvd < 1000) && cyc < 20000) begin
            @(negedge clock);
            cyc++;
            out_ready = ($urandom_range(0, 3) != 0);
            if (!offering) begin
                in_valid = 1'b0;
                if (sent < 1000 && $urandom_range(0, 3) != 0) begin
                    drive(16'($urandom), 4'($urandom_range(0, 15)),
                          1'($urandom), 1'($urandom),
                          1'($urandom), 1'($urandom));
                    model(data_in, shift_amount, shift_direction,
                          signed_mode, round_en, sat_en, cq, cf);
                    offering = 1'b1;
                end
            end
            #1;
            if (out_valid && out_ready) begin
                if (eq.size() == 0) begin
                    chk("rnd_extra_beat", 1, 0);
                end else begin
                    chk("rnd_data", data_out, eq[0]);
                    chk("rnd_flag", sat_flag, ef[0]);
                    if (ef[0])
                        exp_cnt++;
                    void'(eq.pop_front());
                    void'(ef.pop_front());
                end
                recvd++;
            end
            if (in_valid && in_ready) begin
                eq.push_back(cq);
                ef.push_back(cf);
                sent++;
                offering = 1'b0;
            end
        end
        @(negedge clock);
        in_valid = 1'b0;
        @(negedge clock);
        #1;
        chk("rnd_sent", sent, 1000);
        chk("rnd_recvd", recvd, 1000);
        chk("rnd_count", sat_count, exp_cnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
